// File: rtl/sqrt_pkg.sv
// Shared definitions for the square-root controller.
//   - state_e          : FSM state encoding
//   - ITER_W           : width of the iteration counter / iter_o
//   - MAX_ITER_DEFAULT : default iteration limit before forced termination
package sqrt_pkg;

  localparam int ITER_W           = 8;
  localparam int MAX_ITER_DEFAULT = 255;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_INIT = 3'd1,
    ST_TEST = 3'd2,
    ST_INC  = 3'd3,
    ST_ADD  = 3'd4,
    ST_DONE = 3'd5
  } state_e;

endpackage

// File: rtl/sqrt_iter_counter.sv
// Iteration counter for the square-root controller.
// Ports:
//   clk, rst    : clock, asynchronous active-high reset (count -> 0)
//   clr_i       : synchronous clear (highest priority after reset)
//   en_i        : increment request; ignored once the count reaches LIMIT
//   cnt_o       : current count
//   at_limit_o  : count equals LIMIT
module sqrt_iter_counter
  import sqrt_pkg::*;
#(
  parameter int unsigned LIMIT = MAX_ITER_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_i,
  input  logic              en_i,
  output logic [ITER_W-1:0] cnt_o,
  output logic              at_limit_o
);

  localparam logic [ITER_W-1:0] LIMIT_C = ITER_W'(LIMIT);

  logic [ITER_W-1:0] cnt_q;
  logic [ITER_W-1:0] cnt_d;

  // Saturating: the count stops at LIMIT so it can never wrap, which keeps
  // the root register in the datapath from wrapping past 8 bits as well.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q < LIMIT_C)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o      = cnt_q;
  assign at_limit_o = (cnt_q == LIMIT_C);

endmodule

// File: rtl/sqrt_control.sv
// Control FSM for an iterative integer square-root datapath.
// The datapath keeps a root register and a square register; the controller
// boots them, then loops TEST -> INC -> ADD until the square exceeds the
// operand (N_i = 1) or the iteration limit is reached.
// Ports:
//   clk, rst     : clock, asynchronous active-high reset
//   start_i      : request a run (only looked at in IDLE)
//   abort_i      : cancel the run (INIT/TEST/INC/ADD only)
//   N_i          : datapath negative flag, looked at in TEST
//   boot_o       : load init constants into the datapath registers
//   wr_square_o  : square register write enable
//   wr_root_o    : root register write enable
//   muxes_o      : 1 = compare operands, 0 = accumulate operands
//   busy_o       : run in progress (every state but IDLE)
//   done_o       : one-cycle result-valid pulse
//   ovf_o        : last run was cut off by MAX_ITER (held until next start)
//   iter_o       : iterations of the current/last run (held until next start)
module sqrt_control
  import sqrt_pkg::*;
#(
  parameter int unsigned MAX_ITER = MAX_ITER_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic              abort_i,
  input  logic              N_i,
  output logic              boot_o,
  output logic              wr_square_o,
  output logic              wr_root_o,
  output logic              muxes_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              ovf_o,
  output logic [ITER_W-1:0] iter_o
);

  state_e state_q;
  state_e state_d;
  logic   ovf_q;
  logic   ovf_d;
  logic   cnt_clr;
  logic   cnt_en;
  logic   at_limit;

  // Accepting a start wipes the previous run's status; an INC that is being
  // aborted does not count as a completed iteration.
  assign cnt_clr = (state_q == ST_IDLE) && start_i;
  assign cnt_en  = (state_q == ST_INC) && !abort_i;

  sqrt_iter_counter #(
    .LIMIT (MAX_ITER)
  ) u_iter_counter (
    .clk        (clk),
    .rst        (rst),
    .clr_i      (cnt_clr),
    .en_i       (cnt_en),
    .cnt_o      (iter_o),
    .at_limit_o (at_limit)
  );

  always_comb begin
    state_d = state_q;
    ovf_d   = ovf_q;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          state_d = ST_INIT;
          ovf_d   = 1'b0;
        end
      end
      ST_INIT: begin
        state_d = abort_i ? ST_IDLE : ST_TEST;
      end
      ST_TEST: begin
        // N_i wins over the limit: a run that finishes naturally on the
        // last allowed iteration is not an overflow.
        if (abort_i) begin
          state_d = ST_IDLE;
        end else if (N_i) begin
          state_d = ST_DONE;
        end else if (at_limit) begin
          state_d = ST_DONE;
          ovf_d   = 1'b1;
        end else begin
          state_d = ST_INC;
        end
      end
      ST_INC: begin
        state_d = abort_i ? ST_IDLE : ST_ADD;
      end
      ST_ADD: begin
        state_d = abort_i ? ST_IDLE : ST_TEST;
      end
      ST_DONE: begin
        // Result is already committed; abort is too late to matter here.
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ovf_q   <= ovf_d;
    end
  end

  // Moore decode: control outputs depend on the registered state only.
  always_comb begin
    boot_o      = 1'b0;
    wr_square_o = 1'b0;
    wr_root_o   = 1'b0;
    muxes_o     = 1'b0;
    busy_o      = 1'b1;
    done_o      = 1'b0;
    case (state_q)
      ST_IDLE: busy_o = 1'b0;
      ST_INIT: begin
        boot_o      = 1'b1;
        wr_square_o = 1'b1;
        wr_root_o   = 1'b1;
      end
      ST_TEST: muxes_o     = 1'b1;
      ST_INC:  wr_root_o   = 1'b1;
      ST_ADD:  wr_square_o = 1'b1;
      ST_DONE: done_o      = 1'b1;
      default: busy_o      = 1'b0;
    endcase
  end

  assign ovf_o = ovf_q;

endmodule

// File: doc/sqrt_control.md
SQRT_CONTROL -- requirements
Module: sqrt_control

Interface
REQ-001 Parameter MAX_ITER, default 255, is the iteration limit before forced termination (range 1..255).
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 start_i  input  1  request one square-root run; sampled only in IDLE.
REQ-005 abort_i  input  1  cancel the run in progress; sampled in every non-IDLE state.
REQ-006 N_i  input  1  datapath negative flag (sign of valor minus square); sampled only in TEST.
REQ-007 boot_o  output  1  datapath mux select that loads the init constants.
REQ-008 wr_square_o  output  1  square register write enable.
REQ-009 wr_root_o  output  1  root register write enable.
REQ-010 muxes_o  output  1  adder operand select and carry-in (1 = compare, 0 = accumulate).
REQ-011 busy_o  output  1  high in every state except IDLE.
REQ-012 done_o  output  1  one-cycle pulse: the root result is valid.
REQ-013 ovf_o  output  1  high with done_o when the run ended on MAX_ITER; held until the next accepted start.
REQ-014 iter_o  output  8  iterations completed in the current or last run; held until the next accepted start.

Function
REQ-015 FSM states: IDLE, INIT, TEST, INC, ADD, DONE; the state is registered and all control outputs decode from the state only (Moore).
REQ-016 IDLE: all outputs 0 except the held ovf_o/iter_o; start_i=1 -> INIT, clear iter_o and ovf_o.
REQ-017 INIT (1 cycle): boot_o=1, wr_square_o=1, wr_root_o=1, muxes_o=0 -> TEST.
REQ-018 TEST (1 cycle): muxes_o=1, no write enables; N_i=1 -> DONE; N_i=0 and iter_o<MAX_ITER -> INC; N_i=0 and iter_o=MAX_ITER -> DONE with ovf_o set.
REQ-019 INC (1 cycle): wr_root_o=1, muxes_o=0, boot_o=0; iter_o increments at the exit edge -> ADD.
REQ-020 ADD (1 cycle): wr_square_o=1, muxes_o=0, boot_o=0 -> TEST.
REQ-021 DONE (1 cycle): done_o=1, busy_o=1 -> IDLE.
REQ-022 Latency: with k iterations, done_o is high in the cycle after the (2+3k)-th rising edge that follows the start-accept edge.
REQ-023 The block never asserts wr_root_o and wr_square_o together outside INIT, and never asserts boot_o outside INIT.
REQ-024 abort_i=1 in INIT/TEST/INC/ADD -> IDLE at the next edge; no done_o; iter_o holds its partial value; abort takes priority over every other transition.
REQ-025 abort_i in DONE is ignored; done_o still pulses.
REQ-026 start_i while busy_o=1 is ignored and not queued; start_i held high through DONE starts a new run from IDLE on the following edge.
REQ-027 The iteration counter saturates at MAX_ITER and never wraps; the root value therefore never wraps past 8 bits.

Reset
REQ-028 rst=1 forces IDLE immediately, independent of clk: all control outputs, busy_o, done_o and ovf_o = 0, iter_o = 0.
REQ-029 Reset mid-run discards the run with no done_o; the first edge after rst deasserts evaluates IDLE rules.

Structure
REQ-030 The shared package sqrt_pkg holds the state encoding constants, the MAX_ITER default and the iteration-counter width (8).
REQ-031 One sub-module, sqrt_iter_counter (8-bit with clear, enable and saturate-at-limit), implements iter_o; the FSM is inline.

Verification
REQ-032 start pulse with N_i=1 at the first TEST -> INIT then TEST then DONE; done_o in the cycle after edge 2; iter_o=0; ovf_o=0.
REQ-033 start with N_i=0 for 3 TESTs then 1 -> sequence INIT,(TEST,INC,ADD)x3,TEST,DONE; done_o after edge 11; iter_o=3; wr_root_o pulsed 4 times in total.
REQ-034 MAX_ITER=4, N_i held 0 -> done_o after edge 14 with ovf_o=1 and iter_o=4; ovf_o stays 1 in IDLE until the next start.
REQ-035 abort_i=1 during the second INC -> IDLE next edge; no done_o; iter_o=1; busy_o=0.
REQ-036 rst asserted mid-ADD between clock edges -> all outputs 0 immediately; start_i during busy ignored (a second start in TEST produces no extra INIT).
REQ-037 Closed loop with a behavioural datapath model and valor=0, 1, 15, 16, 65535 -> root=0, 1, 3, 4, 255 at done_o; ovf_o=0.
